puf_response_collector: RTL and testbench

Response-side controller for the arbiter PUF. It accepts a base challenge and drives the challenge bus and launch trigger into the selector delay chain. It then samples the arbiter's race-winner bit over REPEAT evaluations per challenge, majority-votes each bit, and assembles RESP_W bits into a response word delivered over a valid/ready handshake. It sits between the PUF fabric (selectors plus arbiter flop) and any key or ID consumer.

---
 rtl/puf_response_collector.sv | 248 ++++++++++++++++++++++++
 tb/tb_puf_response_collector.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/puf_response_collector.sv
// puf_response_collector
//
// Response-side controller for an arbiter PUF. A base challenge is accepted
// over a request handshake. For each response bit i the block applies
// challenge (base + i) mod 2^CH_W to the selector chain and fires the launch
// trigger REPEAT times. It samples the synchronized arbiter output once per
// evaluation and majority-votes the samples into resp_data[i]. After RESP_W
// bits the word is offered on a response handshake.
//
// Each evaluation is SETUP (SETTLE cycles), FIRE (SETTLE cycles, trigger=1),
// SAMPLE (1 cycle) and RELAX (SETTLE cycles).
//
// Optional build macro:
//   PUF_STABILITY_EN - when defined, resp_unstable[i] flags a non-unanimous
//                      vote for bit i. When undefined, resp_unstable is tied
//                      to 0 and the flag logic is not built.
//
// Ports:
//   CLK            in   clock, rising edge
//   RST_N          in   asynchronous active-low reset
//   req_valid      in   request strobe
//   req_ready      out  high only in IDLE (combinational)
//   req_challenge  in   [CH_W]   base challenge, captured on request handshake
//   challenge      out  [CH_W]   challenge applied to the selector chain
//   trigger        out  launch edge into both delay lines
//   arb_in         in   arbiter output, asynchronous (2-flop synchronized)
//   resp_valid     out  response available
//   resp_ready     in   consumer accepts response
//   resp_data      out  [RESP_W] voted response, bit i <-> challenge base+i
//   resp_unstable  out  [RESP_W] per-bit non-unanimous vote flag
//   dbg_state      out  [3]      current FSM state, for debug and checkers
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. resp_valid stays high, and resp_data/resp_unstable stay stable,
// until that transfer. req_valid is ignored outside IDLE and resp_ready is
// ignored outside DONE.

module puf_response_collector #(
  parameter int CH_W   = 4,
  parameter int RESP_W = 8,
  parameter int REPEAT = 3,
  parameter int SETTLE = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CH_W-1:0]   req_challenge,
  output logic [CH_W-1:0]   challenge,
  output logic              trigger,
  input  logic              arb_in,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [RESP_W-1:0] resp_data,
  output logic [RESP_W-1:0] resp_unstable,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W = $clog2(REPEAT + 1);
  localparam int IDX_W = $clog2(RESP_W + 1);
  localparam int PH_W  = $clog2(SETTLE + 1);

  localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT);
  localparam logic [CNT_W-1:0] HALF_C   = CNT_W'(REPEAT / 2);
  localparam logic [IDX_W-1:0] RESP_W_C = IDX_W'(RESP_W);
  localparam logic [PH_W-1:0]  PH_LOAD  = PH_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_FIRE   = 3'd2,
    S_SAMPLE = 3'd3,
    S_RELAX  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [CH_W-1:0]   base_q, base_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  eval_q, eval_d;
  logic [CNT_W-1:0]  ones_q, ones_d;
  logic [CH_W-1:0]   challenge_q, challenge_d;
  logic [RESP_W-1:0] data_q, data_d;
  logic              trigger_q;
  logic              resp_valid_q;
  logic              sync1_q, sync2_q;
  logic              phase_done;
  logic              vote;

`ifdef PUF_STABILITY_EN
  logic [RESP_W-1:0] unst_q, unst_d;
  logic              bit_unstable;
`endif

  assign phase_done = (phase_q == '0);
  assign vote       = (ones_q > HALF_C);

`ifdef PUF_STABILITY_EN
  // Non-unanimous when the ones count is neither all-zero nor all-one.
  assign bit_unstable = (ones_q != '0) && (ones_q != REPEAT_C);
`endif

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    base_d      = base_q;
    idx_d       = idx_q;
    eval_d      = eval_q;
    ones_d      = ones_q;
    challenge_d = challenge_q;
    data_d      = data_q;
`ifdef PUF_STABILITY_EN
    unst_d      = unst_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d     = S_SETUP;
          phase_d     = PH_LOAD;
          base_d      = req_challenge;
          challenge_d = req_challenge;
          idx_d       = '0;
          eval_d      = '0;
          ones_d      = '0;
          data_d      = '0;
`ifdef PUF_STABILITY_EN
          unst_d      = '0;
`endif
        end
      end

      S_SETUP: begin
        if (phase_done) begin
          state_d = S_FIRE;
          phase_d = PH_LOAD;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end

      S_FIRE: begin
        if (phase_done) begin
          state_d = S_SAMPLE;
          phase_d = PH_LOAD;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end

      S_SAMPLE: begin
        // The synchronizer output has settled during FIRE.
        ones_d  = ones_q + CNT_W'(sync2_q);
        eval_d  = eval_q + 1'b1;
        state_d = S_RELAX;
        phase_d = PH_LOAD;
      end

      S_RELAX: begin
        if (phase_done) begin
          phase_d = PH_LOAD;
          if (eval_q < REPEAT_C) begin
            state_d = S_SETUP;
          end else begin
            data_d = data_q | (RESP_W'(vote) << idx_q);
`ifdef PUF_STABILITY_EN
            unst_d = unst_q | (RESP_W'(bit_unstable) << idx_q);
`endif
            eval_d = '0;
            ones_d = '0;
            idx_d  = idx_q + 1'b1;
            if (idx_d == RESP_W_C) begin
              state_d = S_DONE;
            end else begin
              state_d     = S_SETUP;
              challenge_d = base_q + CH_W'(idx_d);
            end
          end
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end

      S_DONE: begin
        if (resp_valid_q && resp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      base_q       <= '0;
      idx_q        <= '0;
      eval_q       <= '0;
      ones_q       <= '0;
      challenge_q  <= '0;
      data_q       <= '0;
      trigger_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      base_q       <= base_d;
      idx_q        <= idx_d;
      eval_q       <= eval_d;
      ones_q       <= ones_d;
      challenge_q  <= challenge_d;
      data_q       <= data_d;
      trigger_q    <= (state_d == S_FIRE);
      // Rises one cycle after DONE is entered; drops on the handshake edge
      // together with the return to IDLE.
      resp_valid_q <= (state_q == S_DONE) && !(resp_valid_q && resp_ready);
      sync1_q      <= arb_in;
      sync2_q      <= sync1_q;
    end
  end

`ifdef PUF_STABILITY_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      unst_q <= '0;
    end else begin
      unst_q <= unst_d;
    end
  end

  assign resp_unstable = unst_q;
`else
  assign resp_unstable = '0;
`endif

  assign req_ready  = (state_q == S_IDLE);
  assign challenge  = challenge_q;
  assign trigger    = trigger_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = data_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_puf_response_collector.sv
// Testbench for puf_response_collector with default parameters
// (CH_W=4, RESP_W=8, REPEAT=3, SETTLE=4). The arbiter is modelled as a
// function of the applied challenge or of the evaluation index. Expected
// responses are hand-computed constants, and the expected challenge sequence
// is generated into exp_q.

module tb_puf_response_collector;

  localparam int SETTLE  = 4;
  localparam int LATENCY = 313;
  localparam int N_EVAL  = 24;

`ifdef PUF_STABILITY_EN
  localparam logic [7:0] TOGGLE_UNST = 8'h04;
`else
  localparam logic [7:0] TOGGLE_UNST = 8'h00;
`endif

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_challenge;
  logic [3:0] challenge;
  logic       trigger;
  logic       arb_in;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_data;
  logic [7:0] resp_unstable;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Arbiter model selection and trigger-pulse bookkeeping.
  int         mode      = 0;
  int         rise_base = 0;
  int         rise_cnt  = 0;
  logic       trig_prev = 1'b0;
  logic [3:0] obs_ch [0:255];
  int         hi_len [0:255];
  logic       moved  [0:255];

  logic [3:0] exp_q[$];

  puf_response_collector dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_challenge (req_challenge),
    .challenge     (challenge),
    .trigger       (trigger),
    .arb_in        (arb_in),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_unstable (resp_unstable),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- arbiter model ----------------
  // mode 0: winner = challenge[0]
  // mode 1: winner = (challenge >= 4'h8)
  // mode 2: bit 2 sees 1,0,1 over its three evaluations, all else 0
  function automatic logic arb_model(input int m, input logic [3:0] ch, input int rel);
    case (m)
      0:       arb_model = ch[0];
      1:       arb_model = ch[3];
      default: arb_model = (rel >= 1) && (((rel - 1) / 3) == 2) && (((rel - 1) % 3) != 1);
    endcase
  endfunction

  assign arb_in = arb_model(mode, challenge, rise_cnt - rise_base);

  // ---------------- trigger monitor ----------------
  // Records the challenge at each trigger rise, the high-pulse length and
  // whether the challenge moved while trigger was high.
  always @(negedge CLK) begin
    if (trigger && !trig_prev) begin
      rise_cnt             <= rise_cnt + 1;
      obs_ch[rise_cnt + 1] <= challenge;
      hi_len[rise_cnt + 1] <= 1;
      moved[rise_cnt + 1]  <= 1'b0;
    end else if (trigger) begin
      hi_len[rise_cnt] <= hi_len[rise_cnt] + 1;
      if (challenge != obs_ch[rise_cnt]) moved[rise_cnt] <= 1'b1;
    end
    trig_prev <= trigger;
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_checks++;
    if (obs !== expd) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expd, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Issue a request and wait for resp_valid; check latency, response and
  // the challenge/trigger sequence seen during collection.
  task automatic collect(input logic [3:0] base, input int m,
                         input logic [7:0] exp_d, input logic [7:0] exp_u);
    int         cycles;
    int         first;
    logic [3:0] ch;
    @(negedge CLK);
    mode      = m;
    rise_base = rise_cnt;
    first     = rise_cnt + 1;
    for (int k = 0; k < N_EVAL; k++) begin
      ch = base + 4'(k / 3);
      exp_q.push_back(ch);
    end
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid     = 1'b1;
    req_challenge = base;
    @(posedge CLK);
    #1;
    req_valid     = 1'b0;
    req_challenge = 4'($urandom_range(0, 15));
    cycles = 0;
    while (!resp_valid && cycles < 2000) begin
      @(posedge CLK);
      #1;
      cycles++;
    end
    check("latency", cycles, LATENCY);
    check("resp_data", {24'd0, resp_data}, {24'd0, exp_d});
    check("resp_unstable", {24'd0, resp_unstable}, {24'd0, exp_u});
    check("trigger_done", {31'd0, trigger}, 32'd0);
    check("eval_count", rise_cnt - rise_base, N_EVAL);
    for (int k = 0; k < N_EVAL; k++) begin
      ch = exp_q.pop_front();
      check("chal", {28'd0, obs_ch[first + k]}, {28'd0, ch});
      check("trig_len", hi_len[first + k], SETTLE);
      check("chal_hold", {31'd0, moved[first + k]}, 32'd0);
    end
  endtask

  // Hold resp_ready low for 'hold' cycles (with a stray request pulse in
  // the middle), then complete the response handshake.
  task automatic handshake(input int hold, input logic [7:0] exp_d);
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      check("hold_valid", {31'd0, resp_valid}, 32'd1);
      check("hold_data", {24'd0, resp_data}, {24'd0, exp_d});
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      req_valid     = (i == hold / 2);
      req_challenge = 4'h9;
    end
    @(negedge CLK);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    check("pre_hs_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge CLK);
    #1;
    resp_ready = 1'b0;
    check("post_hs_valid", {31'd0, resp_valid}, 32'd0);
    check("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  // ---------------- reset + stimulus ----------------
  initial begin : main
    int cycles;
    RST_N         = 1'b0;
    req_valid     = 1'b0;
    req_challenge = 4'h0;
    resp_ready    = 1'b0;
    #12;
    check("rst_challenge", {28'd0, challenge}, 32'd0);
    check("rst_trigger", {31'd0, trigger}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", {24'd0, resp_data}, 32'd0);
    check("rst_resp_unstable", {24'd0, resp_unstable}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge CLK);
    RST_N = 1'b1;

    // Base 3, winner = challenge[0]: challenges 3..A give 8'b01010101.
    collect(4'h3, 0, 8'h55, 8'h00);
    handshake(0, 8'h55);

    // Base E wraps E,F,0..5; winner = challenge >= 8 gives 8'h03.
    // Response is held for 20 cycles with a stray request in between.
    collect(4'hE, 1, 8'h03, 8'h00);
    handshake(20, 8'h03);

    // Bit 2 votes 1,0,1 -> 1, non-unanimous.
    collect(4'h3, 2, 8'h04, TOGGLE_UNST);
    handshake(0, 8'h04);

    // Reset during FIRE of bit 5 (first evaluation of that bit).
    @(negedge CLK);
    mode          = 0;
    rise_base     = rise_cnt;
    req_valid     = 1'b1;
    req_challenge = 4'h0;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    cycles    = 0;
    while ((rise_cnt - rise_base) < 16 && cycles < 1000) begin
      @(negedge CLK);
      #1;
      cycles++;
    end
    check("reach_bit5", rise_cnt - rise_base, 16);
    check("pre_rst_trigger", {31'd0, trigger}, 32'd1);
    check("pre_rst_challenge", {28'd0, challenge}, 32'd5);
    #1;
    RST_N = 1'b0;
    #1;
    check("mid_rst_trigger", {31'd0, trigger}, 32'd0);
    check("mid_rst_challenge", {28'd0, challenge}, 32'd0);
    check("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_resp_data", {24'd0, resp_data}, 32'd0);
    check("mid_rst_resp_unstable", {24'd0, resp_unstable}, 32'd0);
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_state", {29'd0, dbg_state}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Fresh request after reset: challenges 0..7 -> 8'b10101010.
    collect(4'h0, 0, 8'hAA, 8'h00);
    handshake(0, 8'hAA);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
